// File: rtl/pcseq_pkg.sv
// Shared opcode encodings and sequencer state type for pc_sequencer.
package pcseq_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_MUL  = 3'b101;
  localparam logic [OP_W-1:0] OP_WAIT = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    RUN,
    WAIT_BTN,
    MUL_STALL,
    HALT
  } state_t;

endpackage

// File: rtl/btn_edge_sync.sv
// Push-button synchroniser plus one-cycle rise detector; SYNC_STAGES cycles of latency.
// With PCSEQ_DEBOUNCE_EN defined, a DEB_CYCLES-cycle debouncer sits before the edge detector.
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   level;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn};
  end

`ifdef PCSEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          deb_q, deb_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised input disagrees with the held level.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[SYNC_STAGES-1] != deb_q) begin
      if (cnt_q == DW'(DEB_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = deb_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  always_comb begin
    prev_d = level;
  end

  // Reset to 1 so a button held through reset release is not seen as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign btn_rise = level & ~prev_q;

endmodule

// File: rtl/pc_sequencer.sv
// Drives PCincr: advance, hold for WAIT (button rise), MUL (MUL_CYCLES-1 holds) or HALT (until reset).
// Optional button debouncing is enabled with macro PCSEQ_DEBOUNCE_EN.
module pc_sequencer
  import pcseq_pkg::*;
#(
  parameter int OPW         = 3,
  parameter int MUL_CYCLES  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           btn,
  output logic           PCincr,
  output logic           waiting,
  output logic           busy,
  output logic           halted
);

  localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_rise;
  logic          pc_incr;

  btn_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .btn_rise(btn_rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_incr = 1'b0;
    case (state_q)
      RUN: begin
        if (opcode == OPW'(OP_WAIT)) begin
          state_d = WAIT_BTN;
        end else if (opcode == OPW'(OP_HALT)) begin
          state_d = HALT;
        end else if (opcode == OPW'(OP_MUL) && MUL_CYCLES > 1) begin
          cnt_d   = CW'(MUL_CYCLES - 2);
          state_d = MUL_STALL;
        end else begin
          pc_incr = 1'b1;
        end
      end
      // Rises seen in other states are dropped; only a rise here releases the PC.
      WAIT_BTN: begin
        pc_incr = btn_rise;
        if (btn_rise) begin
          state_d = RUN;
        end
      end
      MUL_STALL: begin
        if (cnt_q == '0) begin
          pc_incr = 1'b1;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCincr  = pc_incr;
  assign waiting = (state_q == WAIT_BTN);
  assign busy    = (state_q == MUL_STALL);
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised scoreboard bench for pc_sequencer (default build, debouncer disabled).
module tb_pc_sequencer;
  import pcseq_pkg::*;

  localparam int S  = 2;
  localparam int MC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn;
  logic [2:0] opcode;
  logic       PCincr, waiting, busy, halted;

  pc_sequencer #(
    .OPW        (3),
    .MUL_CYCLES (MC),
    .SYNC_STAGES(S),
    .DEB_CYCLES (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .btn    (btn),
    .PCincr (PCincr),
    .waiting(waiting),
    .busy   (busy),
    .halted (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic inc;
    logic w;
    logic b;
    logic h;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  // Reference model: what the sequencer is "doing", not how it is encoded.
  bit   m_wait, m_halt;
  int   m_stall_left;
  bit   samples[$];
  bit   cur_rise, cur_inc;
  int   pc_model = 0;
  int   pc_dut   = 0;

  function automatic bit hist(int idx);
    if (idx < 0) return 1'b1;
    return samples[idx];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (reset) begin
      m_wait       = 1'b0;
      m_halt       = 1'b0;
      m_stall_left = 0;
      samples.delete();
    end
    cur_rise = hist(samples.size() - S) & ~hist(samples.size() - S - 1);
    e = '0;
    if (m_halt) begin
      e.h = 1'b1;
    end else if (m_stall_left > 0) begin
      e.b   = 1'b1;
      e.inc = (m_stall_left == 1);
    end else if (m_wait) begin
      e.w   = 1'b1;
      e.inc = cur_rise;
    end else begin
      e.inc = !(opcode == OP_WAIT || opcode == OP_HALT || (opcode == OP_MUL && MC > 1));
    end
    cur_inc = e.inc;
    if (!reset && cur_inc) pc_model++;
    exp_q.push_back(e);
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (m_halt) begin
      end else if (m_stall_left > 0) begin
        m_stall_left--;
      end else if (m_wait) begin
        if (cur_rise) m_wait = 1'b0;
      end else if (opcode == OP_WAIT) begin
        m_wait = 1'b1;
      end else if (opcode == OP_HALT) begin
        m_halt = 1'b1;
      end else if (opcode == OP_MUL && MC > 1) begin
        m_stall_left = MC - 1;
      end
      samples.push_back(btn);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty cycle %0d: no expected entry queued", cycle);
    end else begin
      e = exp_q.pop_front();
      if (!reset && PCincr) pc_dut++;
      if ({PCincr, waiting, busy, halted} !== e) begin
        fails++;
        $display("FAIL outputs cycle %0d: got inc/wait/busy/halt=%b required %b",
                 cycle, {PCincr, waiting, busy, halted}, e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    btn    = 1'b0;
    opcode = 3'b000;
    cyc(2);
    reset = 1'b0;
    cyc(5);

    // WAIT released by a 3-cycle button pulse
    opcode = OP_WAIT;
    cyc(4);
    btn = 1'b1;
    cyc(3);
    btn = 1'b0;
    opcode = 3'b000;
    cyc(4);

    // MUL stall
    opcode = OP_MUL;
    cyc(MC);
    opcode = 3'b000;
    cyc(3);

    // HALT ignores buttons and opcode changes until reset
    opcode = OP_HALT;
    cyc(2);
    opcode = 3'b000;
    for (int i = 0; i < 3; i++) begin
      btn = 1'b1; cyc(3);
      btn = 1'b0; cyc(3);
      opcode = OP_WAIT;
    end
    opcode = 3'b000;
    reset  = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(3);

    // Button held through reset release gives no rise until pressed again
    btn   = 1'b1;
    reset = 1'b1;
    cyc(2);
    reset  = 1'b0;
    opcode = OP_WAIT;
    cyc(8);
    btn = 1'b0;
    cyc(3);
    btn = 1'b1;
    cyc(4);
    btn    = 1'b0;
    opcode = 3'b000;
    cyc(4);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      int r;
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
      r = $urandom_range(0, 39);
      if (r == 0) opcode = OP_HALT;
      else        opcode = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) btn = ~btn;
      cyc(1);
    end

    opcode = 3'b000;
    btn    = 1'b0;
    cyc(3);

    tests++;
    if (pc_dut != pc_model) begin
      fails++;
      $display("FAIL pc_count: got %0d advances required %0d", pc_dut, pc_model);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
